uart_rx: RTL and testbench

Serial-to-parallel UART receiver at the front of the receive path. Recovers 8N1 frames from the asynchronous `rx` pin, presents each good byte on `data_out` with a one-cycle `data_valid` strobe, and flips `det_toggle` once per good byte. `det_toggle` feeds the downstream activity/trigger detector, which drives the receive-activity LED.

---
 rtl/uart_pkg.sv | 6 +
 rtl/rx_sync.sv | 16 +
 rtl/uart_rx.sv | 95 +++++++++
 tb/tb_uart_rx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types and constants
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_DEF_CLKS_PER_BIT = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for an asynchronous input with a parameterised reset value
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  // shift the async input through two flops
  always_ff @(posedge Clk)
    if (Rst) sync_q <= {2{RST_VAL}};
    else sync_q <= {sync_q[0], d};
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid strobe, activity toggle and framing-error pulse
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   data_valid,
  output logic                   det_toggle,
  output logic                   frame_err,
  output logic                   busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic rx_s;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic dv_q, dv_d, fe_q, fe_d, tog_q, tog_d, busy_q, busy_d;
  rx_sync #(.RST_VAL(1'b1)) u_sync (.Clk(Clk), .Rst(Rst), .d(rx), .q(rx_s));
  // next-state: the baud counter restarts at each sample point so samples stay mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = data_q;
    dv_d = 1'b0;
    fe_d = 1'b0;
    tog_d = tog_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START:
        if (cnt_q == HALF) begin
          cnt_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      DATA:
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d = {rx_s, sh_q[UART_DATA_W-1:1]};
          bit_d = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? STOP : DATA;
        end
      STOP:
        if (cnt_q == FULL) begin
          state_d = rx_s ? IDLE : WAIT_HIGH;
          dv_d = rx_s;
          fe_d = !rx_s;
          data_d = rx_s ? sh_q : data_q;
          tog_d = tog_q ^ rx_s;
        end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  // register state, counters and all outputs
  always_ff @(posedge Clk)
    if (Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      tog_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      dv_q <= dv_d;
      fe_q <= fe_d;
      tog_q <= tog_d;
      busy_q <= busy_d;
    end
  assign data_out = data_q;
  assign data_valid = dv_q;
  assign frame_err = fe_q;
  assign det_toggle = tog_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level scoreboard
module tb_uart_rx;
  localparam int C = 8;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;
  logic Clk = 1'b0, Rst = 1'b1, rx = 1'b1;
  logic [7:0] data_out;
  logic data_valid, det_toggle, frame_err, busy;
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .Clk(Clk), .Rst(Rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .det_toggle(det_toggle), .frame_err(frame_err), .busy(busy)
  );
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;
  typedef struct {int at; bit fe; logic [7:0] d;} ev_t;
  ev_t exp_q[$];
  logic [7:0] m_data = 8'h00;
  logic m_tog = 1'b0;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // scoreboard: every strobe, and every cycle a strobe is due, is checked against the model
  always @(negedge Clk)
    if (!Rst) begin
      automatic ev_t e = '{at: 0, fe: 1'b0, d: 8'h00};
      automatic bit hit = exp_q.size() > 0 && exp_q[0].at == cyc;
      if (hit) e = exp_q.pop_front();
      if (data_valid || frame_err || hit) begin
        chk("data_valid", data_valid, hit && !e.fe);
        chk("frame_err", frame_err, hit && e.fe);
        if (hit && !e.fe) begin
          m_data = e.d;
          m_tog = ~m_tog;
        end
        chk("data_out", data_out, m_data);
        chk("det_toggle", det_toggle, m_tog);
      end
    end
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask
  // drive one frame with a bit period of p10/10 cycles; cut>0 truncates it with no expectation
  task automatic send(input logic [7:0] b, input bit stop = 1'b1, input int p10 = 10 * C, input int cut = 0);
    automatic logic [9:0] f = {stop, b, 1'b0};
    if (cut == 0) exp_q.push_back(ev_t'{cyc + LAT, !stop, b});
    for (int j = 0; j < (cut != 0 ? cut : p10); j++) begin
      rx = f[(j * 10) / p10];
      step();
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_out"}, data_out, 8'h00);
    chk({tag, "_data_valid"}, data_valid, 1'b0);
    chk({tag, "_det_toggle"}, det_toggle, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask
  initial begin
    int k;
    logic [7:0] b;
    bit stop;
    repeat (3) step();
    chk_reset_vals("reset");
    Rst = 1'b0;
    idle(5);
    send(8'hA5);
    idle(4);
    chk("single_data", data_out, 8'hA5);
    chk("single_toggle", det_toggle, 1'b1);
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    idle(4);
    chk("b2b_data", data_out, 8'h3C);
    chk("b2b_toggle", det_toggle, 1'b0);
    k = cyc;
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    while (cyc < k + 6) step();
    chk("glitch_busy_hi", busy, 1'b1);
    step();
    chk("glitch_busy_lo", busy, 1'b0);
    idle(3);
    send(8'h55);
    idle(2);
    chk("after_glitch_data", data_out, 8'h55);
    send(8'h81, 1'b0);
    rx = 1'b0;
    repeat (40) step();
    chk("ferr_busy_hold", busy, 1'b1);
    chk("ferr_data_kept", data_out, 8'h55);
    chk("ferr_toggle_kept", det_toggle, 1'b1);
    rx = 1'b1;
    step();
    step();
    chk("ferr_busy_wait", busy, 1'b1);
    step();
    chk("ferr_busy_lo", busy, 1'b0);
    idle(3);
    send(8'h5A, 1'b1, 10 * C, 4 * C + 3);
    Rst = 1'b1;
    rx = 1'b1;
    step();
    exp_q.delete();
    m_data = 8'h00;
    m_tog = 1'b0;
    Rst = 1'b0;
    chk_reset_vals("midreset");
    idle(3);
    send(8'hC3);
    idle(3);
    chk("post_reset_data", data_out, 8'hC3);
    chk("post_reset_toggle", det_toggle, 1'b1);
    send(8'h69, 1'b1, 77);
    idle(3);
    chk("fast_data", data_out, 8'h69);
    send(8'h96, 1'b1, 83);
    idle(3);
    chk("slow_data", data_out, 8'h96);
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send(b, stop, 10 * C - 4 + int'($urandom_range(0, 8)));
      idle(int'($urandom_range(0, 3)) + (stop ? 0 : 1) + 1);
    end
    idle(LAT + 10);
    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
